// File: rtl/pwm_ramp_ctrl_if.sv
// Command and status bundle for the PWM duty ramp controller.
// The master side offers target duty commands and observes the ramp status.
// The slave side is the controller itself.
interface pwm_ramp_ctrl_if;
    logic        cmd_valid;
    logic [25:0] cmd_duty;
    logic        cmd_ready;
    logic [25:0] duty_out;
    logic        period_tick;
    logic        busy;
    logic        done;

    modport master (
        output cmd_valid,
        output cmd_duty,
        input  cmd_ready,
        input  duty_out,
        input  period_tick,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_duty,
        output cmd_ready,
        output duty_out,
        output period_tick,
        output busy,
        output done
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller.
// Accepts a target duty, clamps it to the legal window, and walks duty_out
// toward it by at most STEP per PWM frame. Updates happen only at frame
// boundaries, so every frame sees one constant duty value.
module pwm_ramp_ctrl #(
    parameter int unsigned PERIOD   = 2000000,
    parameter int unsigned DUTY_MIN = 50000,
    parameter int unsigned DUTY_MAX = 240000,
    parameter int unsigned STEP     = 1000
) (
    input logic           clk,
    input logic           rst,
    pwm_ramp_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam logic [25:0]        PERIOD_W   = 26'(PERIOD);
    localparam logic [25:0]        DUTY_MIN_W = 26'(DUTY_MIN);
    localparam logic [25:0]        DUTY_MAX_W = 26'(DUTY_MAX);
    localparam logic [25:0]        STEP_W     = 26'(STEP);
    localparam logic signed [26:0] STEP_S     = 27'(STEP);

    logic [25:0]        counter_q, counter_d;
    state_t             state_q, state_d;
    logic [25:0]        duty_q, duty_d;
    logic [25:0]        target_q, target_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               period_tick;
    logic               accept;
    logic [25:0]        clamped;
    logic signed [26:0] diff;
    logic signed [26:0] diff_abs;

    assign period_tick = (counter_q == PERIOD_W);
    assign accept      = bus.cmd_valid && cmd_ready_q;

    // Clamp the offered target into the legal duty window.
    always_comb begin
        clamped = bus.cmd_duty;
        if (bus.cmd_duty < DUTY_MIN_W) begin
            clamped = DUTY_MIN_W;
        end else if (bus.cmd_duty > DUTY_MAX_W) begin
            clamped = DUTY_MAX_W;
        end
    end

    // Signed distance to the target; one extra bit keeps both directions exact.
    always_comb begin
        diff     = $signed({1'b0, target_q}) - $signed({1'b0, duty_q});
        diff_abs = (diff < 0) ? -diff : diff;
    end

    // Next-state logic for the frame counter, ramp FSM and registered outputs.
    // A command repeating the value just reached while done is already
    // pulsing is covered by that pulse, so done never stretches to two cycles.
    always_comb begin
        counter_d   = period_tick ? 26'd0 : counter_q + 26'd1;
        state_d     = state_q;
        duty_d      = duty_q;
        target_d    = target_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = clamped;
                    if (clamped == duty_q) begin
                        done_d = !done_q;
                    end else begin
                        state_d     = RAMP;
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (period_tick) begin
                    if (diff_abs <= STEP_S) begin
                        duty_d      = target_q;
                        state_d     = IDLE;
                        cmd_ready_d = 1'b1;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else if (diff < 0) begin
                        duty_d = duty_q - STEP_W;
                    end else begin
                        duty_d = duty_q + STEP_W;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset wins over any command or tick in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q   <= 26'd0;
            state_q     <= IDLE;
            duty_q      <= DUTY_MIN_W;
            target_q    <= DUTY_MIN_W;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            state_q     <= state_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.duty_out    = duty_q;
    assign bus.period_tick = period_tick;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter PERIOD, default 2000000: the PWM period counter counts 0..PERIOD inclusive, PERIOD+1 cycles per frame.
REQ-002 Parameter DUTY_MIN, default 50000: lowest duty_out value allowed.
REQ-003 Parameter DUTY_MAX, default 240000: highest duty_out value allowed.
REQ-004 Parameter STEP, default 1000: largest duty_out change per frame.
REQ-005 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port cmd_valid, input, 1: a new target duty is offered.
REQ-008 Port cmd_duty, input, 26: requested target duty, in clk cycles of high time.
REQ-009 Port cmd_ready, output, 1: the block accepts a command this cycle.
REQ-010 Port duty_out, output, 26: duty value driven to the PWM generator's duty input.
REQ-011 Port period_tick, output, 1: one-cycle pulse on the last cycle of each frame (counter == PERIOD).
REQ-012 Port busy, output, 1: high while a ramp is in progress.
REQ-013 Port done, output, 1: one-cycle pulse when duty_out reaches the accepted target.

Function
REQ-014 The internal 26-bit frame counter SHALL increment every cycle and wrap from PERIOD to 0; period_tick SHALL be combinationally high when counter == PERIOD.
REQ-015 The state machine SHALL have two states, IDLE and RAMP.
REQ-016 cmd_ready SHALL be high in IDLE and low in RAMP; busy SHALL equal (state == RAMP).
REQ-017 Handshake: a command is accepted on a cycle with cmd_valid && cmd_ready; cmd_valid held during RAMP SHALL NOT be accepted until the first cycle back in IDLE.
REQ-018 On acceptance the target SHALL be captured clamped: below DUTY_MIN becomes DUTY_MIN, above DUTY_MAX becomes DUTY_MAX.
REQ-019 If the clamped target equals duty_out at acceptance, the block SHALL stay in IDLE and assert done on the next cycle.
REQ-020 Otherwise the block SHALL enter RAMP on the next cycle.
REQ-021 duty_out SHALL change only on the clock edge that ends a cycle with period_tick high and state == RAMP, so every PWM frame sees one constant duty value.
REQ-022 At each such tick in RAMP: if |target - duty_out| <= STEP, duty_out becomes target, state returns to IDLE, and done pulses for the following cycle.
REQ-023 Otherwise at that tick, duty_out SHALL move toward target by exactly STEP.
REQ-024 If acceptance and period_tick occur in the same cycle, that tick SHALL NOT update duty_out; the first update occurs at the next tick.
REQ-025 The difference SHALL be computed in 27-bit signed width; duty_out SHALL never leave [DUTY_MIN, DUTY_MAX], with no underflow or overflow.
REQ-026 done SHALL never be high for two consecutive cycles, and SHALL never be high while busy is high.

Reset
REQ-027 While rst is high at a clock edge, the block SHALL set: counter = 0, state = IDLE, duty_out = DUTY_MIN, target = DUTY_MIN, cmd_ready = 1, busy = 0, done = 0.
REQ-028 Reset asserted mid-ramp SHALL abandon the ramp; no done pulse results from the abandoned command.
REQ-029 Reset SHALL take priority over a simultaneous command or tick.

Verification (bench parameters: PERIOD=9, DUTY_MIN=50, DUTY_MAX=240, STEP=10)
REQ-030 Ramp up: after reset, accept cmd_duty=100 -> duty_out steps 60,70,80,90,100 at five consecutive ticks; busy high throughout; done pulses once after 100.
REQ-031 Partial last step and down-ramp: from 50, accept 73 -> 60, 70, 73 then done; then accept 55 -> 63, 55 then done.
REQ-032 Clamping: accept 300 -> target 240, and duty_out never exceeds 240; accept 10 while duty_out = 50 -> stays in IDLE with no duty change, done on the next cycle.
REQ-033 Handshake: hold cmd_valid with 200 during a ramp -> cmd_ready stays low and the command is not accepted; it is accepted on the first IDLE cycle; acceptance coincident with a tick produces no update until the next tick.
REQ-034 Reset mid-ramp: while ramping 50 to 200, assert rst at duty_out = 120 -> next cycle duty_out = 50, busy = 0, cmd_ready = 1, counter = 0, and no done pulse.
REQ-035 Frame integrity: in every scenario duty_out changes only on the edge after period_tick, and period_tick recurs every 10 cycles.
